// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between the round-robin arbiter and the requesters/downstream it serves.
// The master side is the arbiter: it takes the requests and ready, and drives the grant and mux selects.
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic       ready;
   logic [3:0] gnt;
   logic       s0;
   logic       s1;
   logic       valid;

   modport master (
      input  req,
      input  ready,
      output gnt,
      output s0,
      output s1,
      output valid
   );

   modport slave (
      output req,
      output ready,
      input  gnt,
      input  s0,
      input  s1,
      input  valid
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the s1:s0 selects of a shared 4:1 mux.
// A grant is held for up to MAX_BEATS accepted beats while another requester is waiting.
module mux4_rr_arbiter #(
   parameter int MAX_BEATS = 8
) (
   input  logic             clk,
   input  logic             rst,
   mux4_rr_arbiter_if.master bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

   state_t     state_q, state_n;
   logic [1:0] ptr_q, ptr_n;
   logic [1:0] g_q, g_n;
   logic [3:0] cnt_q, cnt_n;
   logic [3:0] gnt_q, gnt_n;
   logic [1:0] sel_q, sel_n;
   logic       valid_q, valid_n;

   logic [3:0] others;
   logic [3:0] cnt_inc;
   logic       hit_max;
   logic       beat;
   logic       release_a;
   logic       release_b;

   function automatic logic [3:0] onehot(input logic [1:0] idx);
      onehot = 4'b0001 << idx;
   endfunction

   // First set bit of mask, scanning upward from start and wrapping modulo 4.
   function automatic logic [1:0] first_set(input logic [3:0] mask, input logic [1:0] start);
      logic [1:0] idx;
      logic       found;
      first_set = start;
      found     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = start + 2'(i);
         if (mask[idx] && !found) begin
            first_set = idx;
            found     = 1'b1;
         end
      end
   endfunction

   // Next-state logic; registered outputs are derived from the next state so they
   // always agree with each other and change only at the clock edge.
   always_comb begin
      state_n   = state_q;
      ptr_n     = ptr_q;
      g_n       = g_q;
      cnt_n     = cnt_q;
      others    = bus.req & ~onehot(g_q);
      cnt_inc   = cnt_q + 4'd1;
      hit_max   = (cnt_inc == MAX_CNT);
      beat      = 1'b0;
      release_a = 1'b0;
      release_b = 1'b0;

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               g_n     = first_set(bus.req, ptr_q);
               cnt_n   = 4'd0;
               state_n = GRANT;
            end
         end
         GRANT: begin
            beat      = valid_q && bus.ready;
            release_a = !bus.req[g_q];
            release_b = beat && hit_max && (|others);
            if (release_a || release_b) begin
               ptr_n = g_q + 2'd1;
               cnt_n = 4'd0;
               if (|others) begin
                  g_n = first_set(others, g_q + 2'd1);
               end else begin
                  state_n = IDLE;
               end
            end else if (beat) begin
               cnt_n = hit_max ? 4'd0 : cnt_inc;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      gnt_n   = (state_n == GRANT) ? onehot(g_n) : 4'b0000;
      sel_n   = (state_n == GRANT) ? g_n : 2'b00;
      valid_n = (state_n == GRANT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         g_q     <= 2'd0;
         cnt_q   <= 4'd0;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_n;
         ptr_q   <= ptr_n;
         g_q     <= g_n;
         cnt_q   <= cnt_n;
         gnt_q   <= gnt_n;
         sel_q   <= sel_n;
         valid_q <= valid_n;
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.s0    = sel_q[0];
   assign bus.s1    = sel_q[1];
   assign bus.valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic, all checked
// against an owner/beat-count reference model through a per-cycle scoreboard.
module tb_mux4_rr_arbiter;

   localparam int MAX_BEATS = 4;

   typedef struct {
      logic [3:0] gnt;
      logic       valid;
      logic [1:0] sel;
   } exp_t;

   logic clk;
   logic rst;
   mux4_rr_arbiter_if bus ();

   mux4_rr_arbiter #(.MAX_BEATS(MAX_BEATS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   // Reference model state: owner is the granted requester, -1 while idle.
   int owner = -1;
   int start = 0;
   int beats = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [3:0] mask, input int from, input int exclude);
      int idx;
      for (int i = 0; i < 4; i++) begin
         idx = (from + i) % 4;
         if (mask[idx] && idx != exclude) return idx;
      end
      return -1;
   endfunction

   task automatic check_output(input string name, input logic [3:0] gnt_exp,
                               input logic valid_exp, input logic [1:0] sel_exp);
      n_cmp++;
      if (bus.gnt !== gnt_exp || bus.valid !== valid_exp || {bus.s1, bus.s0} !== sel_exp) begin
         n_bad++;
         $display("[TB] FAIL %s at %0t: got gnt=%b valid=%b sel=%b, need gnt=%b valid=%b sel=%b",
                  name, $time, bus.gnt, bus.valid, {bus.s1, bus.s0}, gnt_exp, valid_exp, sel_exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic rst_v, input logic [3:0] req_v, input logic ready_v);
      rst       = rst_v;
      bus.req   = req_v;
      bus.ready = ready_v;
   endtask

   // Reference model: advance one edge from the sampled inputs and queue the expected outputs.
   initial begin
      exp_t e;
      bit   others;
      forever begin
         @(posedge clk);
         if (rst) begin
            owner = -1;
            start = 0;
            beats = 0;
         end else if (owner < 0) begin
            if (bus.req != 4'b0000) begin
               owner = pick(bus.req, start, -1);
               beats = 0;
            end
         end else begin
            others = (pick(bus.req, owner + 1, owner) >= 0);
            if (bus.ready) beats++;
            if (!bus.req[owner] || (beats == MAX_BEATS && others)) begin
               start = (owner + 1) % 4;
               owner = pick(bus.req, owner + 1, owner);
               beats = 0;
            end else if (beats == MAX_BEATS) begin
               beats = 0;
            end
         end
         e.gnt   = (owner < 0) ? 4'b0000 : 4'(1 << owner);
         e.valid = (owner >= 0);
         e.sel   = (owner < 0) ? 2'b00 : 2'(owner);
         sb.push_back(e);
      end
   end

   // Monitor: compare each presented output against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("scoreboard", e.gnt, e.valid, e.sel);
         end
      end
   end

   initial begin
      logic [3:0] r;
      apply_stimulus(1'b1, 4'b1111, 1'b1);

      // Reset with full contention, then rotation through all four requesters.
      tick();
      check_output("reset_hold0", 4'b0000, 1'b0, 2'b00);
      tick();
      check_output("reset_hold1", 4'b0000, 1'b0, 2'b00);
      apply_stimulus(1'b0, 4'b1111, 1'b1);
      tick();
      check_output("first_grant", 4'b0001, 1'b1, 2'b00);
      for (int rr = 0; rr < 5; rr++) begin
         for (int k = 0; k < MAX_BEATS; k++) begin
            if (rr != 0 || k != 0) begin
               tick();
               check_output("rotation", 4'(1 << (rr % 4)), 1'b1, 2'(rr % 4));
            end
         end
      end

      // Lone requester is held well past MAX_BEATS.
      apply_stimulus(1'b1, 4'b0100, 1'b1);
      tick();
      apply_stimulus(1'b0, 4'b0100, 1'b1);
      for (int k = 0; k < 20; k++) begin
         tick();
         check_output("single_hold", 4'b0100, 1'b1, 2'b10);
      end

      // Backpressure: two beats, a long stall, then two more beats before hand-over.
      apply_stimulus(1'b1, 4'b0011, 1'b1);
      tick();
      apply_stimulus(1'b0, 4'b0011, 1'b1);
      tick();
      check_output("bp_grant", 4'b0001, 1'b1, 2'b00);
      tick();
      tick();
      apply_stimulus(1'b0, 4'b0011, 1'b0);
      for (int k = 0; k < 10; k++) begin
         tick();
         check_output("bp_stall", 4'b0001, 1'b1, 2'b00);
      end
      apply_stimulus(1'b0, 4'b0011, 1'b1);
      tick();
      check_output("bp_beat3", 4'b0001, 1'b1, 2'b00);
      tick();
      check_output("bp_handover", 4'b0010, 1'b1, 2'b01);

      // Early release of index 1 to index 3, then index 3 releases to index 0.
      apply_stimulus(1'b0, 4'b1010, 1'b1);
      tick();
      tick();
      apply_stimulus(1'b0, 4'b1000, 1'b1);
      tick();
      check_output("early_release", 4'b1000, 1'b1, 2'b11);
      apply_stimulus(1'b0, 4'b0101, 1'b1);
      tick();
      check_output("ptr_wrap", 4'b0001, 1'b1, 2'b00);

      // Reset pulse in the middle of a grant to index 3.
      apply_stimulus(1'b0, 4'b1000, 1'b1);
      tick();
      check_output("mid_grant", 4'b1000, 1'b1, 2'b11);
      apply_stimulus(1'b1, 4'b1111, 1'b1);
      tick();
      check_output("mid_reset", 4'b0000, 1'b0, 2'b00);
      apply_stimulus(1'b0, 4'b1111, 1'b1);
      tick();
      check_output("post_reset", 4'b0001, 1'b1, 2'b00);

      // Random traffic checked only through the scoreboard.
      r = 4'b0000;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         else if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
         apply_stimulus($urandom_range(0, 199) == 0, r, $urandom_range(0, 3) != 0);
         tick();
      end

      apply_stimulus(1'b0, 4'b0000, 1'b0);
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
